// File: rtl/mem_pkg.sv
// Shared memory-side types: doubleword geometry, byte mask and doubleword typedefs.
// Reused by the memory-management unit and the byte responder.
package mem_pkg;

  localparam int WORD_BYTES = 8;
  localparam int LANE_W     = 3;

  typedef logic [7:0]              byte_t;
  typedef logic [WORD_BYTES-1:0]   byte_mask_t;
  typedef logic [8*WORD_BYTES-1:0] dword_t;

endpackage

// File: rtl/write_combine_buffer.sv
// Single-entry byte write-combining buffer; one store per cycle, no back-pressure.
// Commit is combinational from current state and strobes; forwarding is zero-latency.
module write_combine_buffer
  import mem_pkg::*;
#(
  parameter int IDX_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             store,
  input  logic             flush,
  input  logic [IDX_W-1:0] idx,
  input  logic [LANE_W-1:0] lane,
  input  byte_t            data,
  output logic             valid,
  output logic             commit,
  output logic [IDX_W-1:0] commit_idx,
  output dword_t           commit_data,
  output byte_mask_t       commit_mask,
  output logic             hit,
  output byte_t            fwd_byte
);

  logic             wcb_valid;
  logic [IDX_W-1:0] wcb_idx;
  dword_t           wcb_data;
  byte_mask_t       wcb_mask;

  logic idx_match;
  logic fresh;

  assign idx_match = wcb_valid && (wcb_idx == idx);

  // Eviction and flush share one commit of the old contents; reset suppresses it.
  assign commit      = !rst && wcb_valid && (flush || (store && !idx_match));
  assign commit_idx  = wcb_idx;
  assign commit_data = wcb_data;
  assign commit_mask = wcb_mask;

  // A store alongside a flush always opens a new single-lane buffer.
  assign fresh = flush || !idx_match;

  always_ff @(posedge clk) begin
    if (rst) begin
      wcb_valid <= 1'b0;
      wcb_mask  <= '0;
    end else if (store) begin
      wcb_valid <= 1'b1;
      wcb_idx   <= idx;
      if (fresh) begin
        wcb_data <= dword_t'(data) << (8 * lane);
        wcb_mask <= byte_mask_t'(1) << lane;
      end else begin
        wcb_data[8*lane +: 8] <= data;
        wcb_mask[lane]        <= 1'b1;
      end
    end else if (flush) begin
      wcb_valid <= 1'b0;
      wcb_mask  <= '0;
    end
  end

  assign valid    = wcb_valid;
  assign hit      = idx_match && wcb_mask[lane];
  assign fwd_byte = wcb_data[8*lane +: 8];

endmodule

// File: rtl/byte_mem_responder.sv
// Byte-wide load/store responder over a doubleword array with write-combining.
// Reads are combinational with buffer forwarding; stores accepted every cycle, never stalled.
module byte_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 512,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] mem_addr,
  input  logic        write_mem,
  input  logic [7:0]  data_mem,
  input  logic        flush,
  output logic [7:0]  mem_o,
  output logic        dirty
);

  logic [IDX_W-1:0]  index;
  logic [LANE_W-1:0] lane;
  logic              unused_addr_hi;

  // Upper address bits alias onto the array.
  assign index          = mem_addr[IDX_W+2:3];
  assign lane           = mem_addr[2:0];
  assign unused_addr_hi = ^mem_addr[63:IDX_W+3];

  dword_t words [DEPTH_WORDS];

  logic             commit;
  logic [IDX_W-1:0] commit_idx;
  dword_t           commit_data;
  byte_mask_t       commit_mask;
  logic             hit;
  byte_t            fwd_byte;
  dword_t           rd_word;

  write_combine_buffer #(
    .IDX_W (IDX_W)
  ) u_wcb (
    .clk         (clk),
    .rst         (rst),
    .store       (write_mem),
    .flush       (flush),
    .idx         (index),
    .lane        (lane),
    .data        (data_mem),
    .valid       (dirty),
    .commit      (commit),
    .commit_idx  (commit_idx),
    .commit_data (commit_data),
    .commit_mask (commit_mask),
    .hit         (hit),
    .fwd_byte    (fwd_byte)
  );

  // Byte-enabled write: unmasked lanes keep their array contents.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (commit_mask[b]) begin
          words[commit_idx][8*b +: 8] <= commit_data[8*b +: 8];
        end
      end
    end
  end

  assign rd_word = words[index];
  assign mem_o   = hit ? fwd_byte : rd_word[8*lane +: 8];

endmodule

// File: tb/tb_byte_mem_responder.sv
// Directed scoreboard bench for byte_mem_responder (default DEPTH_WORDS=512).
module tb_byte_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] mem_addr;
  logic        write_mem;
  logic [7:0]  data_mem;
  logic        flush;
  logic [7:0]  mem_o;
  logic        dirty;

  int          n_assert   = 0;
  int          n_fail     = 0;
  int          commit_cnt = 0;
  logic [63:0] exp_q[$];

  byte_mem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .mem_addr  (mem_addr),
    .write_mem (write_mem),
    .data_mem  (data_mem),
    .flush     (flush),
    .mem_o     (mem_o),
    .dirty     (dirty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dut.commit === 1'b1) commit_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    write_mem = 1'b0;
    flush     = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic store(input logic [63:0] a, input logic [7:0] d);
    mem_addr  = a;
    data_mem  = d;
    write_mem = 1'b1;
    tick();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
  endtask

  task automatic rd(input string tag, input logic [63:0] a, input logic [7:0] e);
    exp_q.push_back({56'b0, e});
    mem_addr  = a;
    write_mem = 1'b0;
    #1;
    check(tag, {56'b0, mem_o}, exp_q.pop_front());
  endtask

  initial begin
    int c0;
    rst       = 1'b1;
    write_mem = 1'b0;
    flush     = 1'b0;
    mem_addr  = '0;
    data_mem  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_dirty", {63'b0, dirty}, 64'h0);

    // Single doubleword burst
    for (int i = 0; i < 8; i++) store(64'h40 + 64'(i), 8'(8'hA0 + i));
    do_flush();
    check("t1_preload", dut.words[8], 64'hA7A6_A5A4_A3A2_A1A0);
    for (int i = 0; i < 8; i++) store(64'h40 + 64'(i), 8'(17 * (i + 1)));
    check("t1_dirty", {63'b0, dirty}, 64'h1);
    for (int i = 0; i < 8; i++) rd("t1_fwd", 64'h40 + 64'(i), 8'(17 * (i + 1)));
    check("t1_array_unchanged", dut.words[8], 64'hA7A6_A5A4_A3A2_A1A0);
    do_flush();
    check("t1_array_flushed", dut.words[8], 64'h8877_6655_4433_2211);
    check("t1_clean", {63'b0, dirty}, 64'h0);
    rd("t1_array_read", 64'h43, 8'h44);

    // Partial eviction
    for (int i = 0; i < 8; i++) store(64'h10 + 64'(i), 8'hFF);
    do_flush();
    c0 = commit_cnt;
    store(64'h13, 8'hAB);
    store(64'h28, 8'hCD);
    check("t2_word2", dut.words[2], 64'hFFFF_FFFF_ABFF_FFFF);
    check("t2_mask", {56'b0, dut.u_wcb.wcb_mask}, 64'h01);
    rd("t2_fwd", 64'h28, 8'hCD);
    check("t2_commits", 64'(commit_cnt - c0), 64'd1);
    do_flush();

    // Same-edge flush and store
    store(64'h08, 8'h5A);
    c0        = commit_cnt;
    mem_addr  = 64'h09;
    data_mem  = 8'h3C;
    write_mem = 1'b1;
    flush     = 1'b1;
    tick();
    check("t3_word1_lane0", {56'b0, dut.words[1][7:0]}, 64'h5A);
    check("t3_mask", {56'b0, dut.u_wcb.wcb_mask}, 64'h02);
    check("t3_dirty", {63'b0, dirty}, 64'h1);
    check("t3_commits", 64'(commit_cnt - c0), 64'd1);
    rd("t3_fwd", 64'h09, 8'h3C);
    rd("t3_array", 64'h08, 8'h5A);
    do_flush();
    check("t3_word1_lane1", {56'b0, dut.words[1][15:8]}, 64'h3C);

    // Reset mid-burst, with a store and flush on the reset edge
    for (int i = 0; i < 8; i++) store(64'h20 + 64'(i), 8'(8 - i));
    do_flush();
    for (int i = 0; i < 3; i++) store(64'h20 + 64'(i), 8'(8'hE0 + i));
    c0        = commit_cnt;
    rst       = 1'b1;
    mem_addr  = 64'h38;
    data_mem  = 8'h99;
    write_mem = 1'b1;
    flush     = 1'b1;
    tick();
    check("t4_dirty", {63'b0, dirty}, 64'h0);
    check("t4_word4", dut.words[4], 64'h0102_0304_0506_0708);
    check("t4_commits", 64'(commit_cnt - c0), 64'd0);
    rd("t4_read", 64'h21, 8'h07);

    // Aliasing modulo 8*DEPTH_WORDS
    store(64'h1000, 8'h77);
    do_flush();
    rd("t5_alias", 64'h0, 8'h77);

    // Overwrite within buffer
    c0 = commit_cnt;
    store(64'h30, 8'h01);
    store(64'h30, 8'h02);
    rd("t6_fwd", 64'h30, 8'h02);
    do_flush();
    check("t6_word6_lane0", {56'b0, dut.words[6][7:0]}, 64'h02);
    check("t6_commits", 64'(commit_cnt - c0), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
